// File: rtl/vga_pkg.sv
// Shared VGA geometry, widths and colour constants for the height graph display.
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned GRID_SPACING = 32;
  localparam int unsigned NUM_BARS     = 10;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned HEIGHT_W     = 8;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned SUM_W        = 11;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = 6'b00_00_00;
  localparam rgb_t RGB_RED   = 6'b11_00_00;
  localparam rgb_t RGB_GREEN = 6'b00_11_00;
  localparam rgb_t RGB_BLUE  = 6'b00_00_11;
  localparam rgb_t RGB_GREY  = 6'b01_01_01;

endpackage

// File: rtl/bar_locator.sv
// Maps a pixel column to its bar slot index and flags the blank gap columns.
module bar_locator
  import vga_pkg::*;
#(
  parameter int unsigned BAR_PITCH = 64,
  parameter int unsigned BAR_GAP   = 4
) (
  input  logic [COORD_W-1:0] col,
  output logic [IDX_W-1:0]   idx_c,
  output logic               in_gap_c,
  output logic               in_range_c
);

  logic [COORD_W-1:0] quot;
  logic [COORD_W-1:0] rem;

  assign quot = col / COORD_W'(BAR_PITCH);
  assign rem  = col % COORD_W'(BAR_PITCH);

  // Columns past the last slot never belong to a bar.
  assign in_range_c = quot < COORD_W'(NUM_BARS);
  assign idx_c      = in_range_c ? quot[IDX_W-1:0] : '1;
  assign in_gap_c   = (rem < COORD_W'(BAR_GAP)) ||
                      (rem >= COORD_W'(BAR_PITCH - BAR_GAP));

endmodule

// File: rtl/height_graph_gen.sv
// Draws a 10-bar height histogram over a grid; two-stage pixel pipeline with
// per-frame snapshot of the history so a frame never shows a mid-frame update.
module height_graph_gen #(
  parameter int unsigned H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int unsigned BAR_PITCH = 64,
  parameter int unsigned BAR_GAP   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [vga_pkg::COORD_W-1:0]   vga_col,
  input  logic [vga_pkg::COORD_W-1:0]   vga_row,
  input  logic                          vga_valid,
  input  logic                          h_sync_in,
  input  logic                          v_sync_in,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_0,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_1,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_2,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_3,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_4,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_5,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_6,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_7,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_8,
  input  logic [vga_pkg::HEIGHT_W-1:0]  hist_9,
  input  logic [vga_pkg::IDX_W-1:0]     sel_idx,
  output logic [1:0]                    red,
  output logic [1:0]                    green,
  output logic [1:0]                    blue,
  output logic                          h_sync_out,
  output logic                          v_sync_out
);

  import vga_pkg::rgb_t;
  import vga_pkg::COORD_W;
  import vga_pkg::HEIGHT_W;
  import vga_pkg::IDX_W;
  import vga_pkg::SUM_W;
  import vga_pkg::NUM_BARS;
  import vga_pkg::GRID_SPACING;
  import vga_pkg::RGB_BLACK;
  import vga_pkg::RGB_RED;
  import vga_pkg::RGB_GREEN;
  import vga_pkg::RGB_BLUE;
  import vga_pkg::RGB_GREY;

  logic [HEIGHT_W-1:0] hist [NUM_BARS];
  logic [HEIGHT_W-1:0] snap [NUM_BARS];
  logic [IDX_W-1:0]    snap_sel;
  logic                snap_now_c;

  always_comb begin
    hist[0] = hist_0;
    hist[1] = hist_1;
    hist[2] = hist_2;
    hist[3] = hist_3;
    hist[4] = hist_4;
    hist[5] = hist_5;
    hist[6] = hist_6;
    hist[7] = hist_7;
    hist[8] = hist_8;
    hist[9] = hist_9;
  end

  // Capture happens at the first pixel of the first blanking row.
  assign snap_now_c = (vga_row == COORD_W'(V_ACTIVE)) && (vga_col == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BARS); i++) snap[i] <= '0;
      snap_sel <= '1;
    end else if (snap_now_c) begin
      for (int i = 0; i < int'(NUM_BARS); i++) snap[i] <= hist[i];
      snap_sel <= sel_idx;
    end
  end

  logic [IDX_W-1:0]    loc_idx_c;
  logic                loc_gap_c;
  logic                loc_in_range_c;
  logic [HEIGHT_W-1:0] sel_value_c;
  logic                visible_c;

  bar_locator #(
    .BAR_PITCH (BAR_PITCH),
    .BAR_GAP   (BAR_GAP)
  ) u_bar_locator (
    .col        (vga_col),
    .idx_c      (loc_idx_c),
    .in_gap_c   (loc_gap_c),
    .in_range_c (loc_in_range_c)
  );

  assign sel_value_c = loc_in_range_c ? snap[loc_idx_c] : '0;
  assign visible_c   = vga_valid &&
                       (vga_col < COORD_W'(H_ACTIVE)) &&
                       (vga_row < COORD_W'(V_ACTIVE));

  logic                s1_valid;
  logic [IDX_W-1:0]    s1_idx;
  logic                s1_gap;
  logic                s1_in_range;
  logic [HEIGHT_W-1:0] s1_value;
  logic [COORD_W-1:0]  s1_row;
  logic                s1_hs;
  logic                s1_vs;

  // Stage 1: slot lookup and per-pixel bar height.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      s1_gap      <= 1'b0;
      s1_in_range <= 1'b0;
      s1_value    <= '0;
      s1_row      <= '0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
    end else begin
      s1_valid    <= visible_c;
      s1_idx      <= loc_idx_c;
      s1_gap      <= loc_gap_c;
      s1_in_range <= loc_in_range_c;
      s1_value    <= sel_value_c;
      s1_row      <= vga_row;
      s1_hs       <= h_sync_in;
      s1_vs       <= v_sync_in;
    end
  end

  logic [SUM_W-1:0] fill_sum_c;
  logic [SUM_W-1:0] grid_dist_c;
  logic             inside_c;
  logic             grid_c;
  logic             bar_pix_c;
  rgb_t             pix_c;

  assign fill_sum_c  = {1'b0, s1_row} + {3'b0, s1_value};
  assign inside_c    = fill_sum_c >= SUM_W'(V_ACTIVE);
  assign grid_dist_c = SUM_W'(V_ACTIVE - 1) - {1'b0, s1_row};
  assign grid_c      = (grid_dist_c % SUM_W'(GRID_SPACING)) == '0;
  assign bar_pix_c   = inside_c && s1_in_range && !s1_gap;

  // Colour priority: highlighted bar, newest bar, other bars, grid, background.
  always_comb begin
    pix_c = RGB_BLACK;
    if (!s1_valid)                               pix_c = RGB_BLACK;
    else if (bar_pix_c && (s1_idx == snap_sel))  pix_c = RGB_RED;
    else if (bar_pix_c && (s1_idx == '0))        pix_c = RGB_GREEN;
    else if (bar_pix_c)                          pix_c = RGB_BLUE;
    else if (grid_c)                             pix_c = RGB_GREY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else begin
      red        <= pix_c.r;
      green      <= pix_c.g;
      blue       <= pix_c.b;
      h_sync_out <= s1_hs;
      v_sync_out <= s1_vs;
    end
  end

endmodule

// File: doc/height_graph_gen.md
HEIGHT_GRAPH_GEN -- requirements
Module: height_graph_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible columns.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, visible rows.
REQ-003 The block SHALL have parameter BAR_PITCH, default 64, columns per bar slot.
REQ-004 The block SHALL have parameter BAR_GAP, default 4, blank columns on each side of every bar.
REQ-005 The block SHALL have ports: clk  in  1  VGA pixel clock (25.175 MHz); rst  in  1  reset.
REQ-006 Ports: vga_col  in  10  pixel column; vga_row  in  10  pixel row; vga_valid  in  1  visible-area flag.
REQ-007 Ports: h_sync_in  in  1, v_sync_in  in  1  active-low raw syncs from the timing generator.
REQ-008 Ports: hist_0..hist_9  in  8 each  stored heights in inches, hist_0 newest; sel_idx  in  4  history entry shown on the second display.
REQ-009 Ports: red, green, blue  out  2 each  pixel colour; h_sync_out, v_sync_out  out  1  delayed syncs.
REQ-010 The block SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-011 Snapshot: on the single cycle with vga_row==V_ACTIVE and vga_col==0, the block SHALL copy hist_0..hist_9 into internal snap_0..snap_9; all drawing SHALL use snap values, so no frame shows a mid-frame update.
REQ-012 sel_idx SHALL be captured into snap_sel on the same cycle.
REQ-013 Pipeline stage 1 SHALL register: bar index = vga_col / BAR_PITCH (0..9), in_gap = (col mod BAR_PITCH < BAR_GAP) or (col mod BAR_PITCH >= BAR_PITCH-BAR_GAP), the selected snap value, row, and valid.
REQ-014 Pipeline stage 2 SHALL register the colour outputs; total latency from vga_* inputs to red/green/blue SHALL be exactly 2 clk cycles.
REQ-015 h_sync_out and v_sync_out SHALL be h_sync_in and v_sync_in delayed by exactly 2 cycles.
REQ-016 Bar fill rule: a pixel is inside the bar when {1'b0,row} + {3'b0,value} >= V_ACTIVE, computed at 11 bits with no truncation.
REQ-017 A value of 0 SHALL draw no bar pixels; a value of 255 SHALL fill rows 225..479.
REQ-018 Colour priority, first match wins:
  - valid==0 -> 000000;
  - inside bar, not in_gap, index==snap_sel -> red=11, green=00, blue=00;
  - inside bar, not in_gap, index==0 -> red=00, green=11, blue=00;
  - inside bar, not in_gap -> red=00, green=00, blue=11;
  - grid row ((V_ACTIVE-1-row) mod 32 == 0) -> red=01, green=01, blue=01;
  - otherwise black.
REQ-019 snap_sel >= 10 SHALL highlight no bar.
REQ-020 Columns >= 10*BAR_PITCH SHALL be treated as outside any bar; a grid line is still drawn there.
REQ-021 Rows and columns outside the visible area SHALL produce black regardless of snap contents.

Reset
REQ-022 While rst=1 at a clk edge:
  - red, green and blue SHALL be 0;
  - h_sync_out and v_sync_out SHALL be 1;
  - all pipeline valid bits SHALL be 0;
  - snap_0..snap_9 SHALL be 0;
  - snap_sel SHALL be 15.
REQ-023 After rst deasserts mid-frame, the first 2 cycles SHALL output black with inactive syncs, and bars SHALL stay empty until the next snapshot cycle.

Structure
REQ-024 A shared package vga_pkg SHALL hold H_ACTIVE, V_ACTIVE, the grid spacing (32), the colour constants and the 2-bit rgb struct typedef.
REQ-025 One sub-module, bar_locator, SHALL implement the stage-1 column-to-index and gap computation.

Verification
REQ-026 snap row: hist_3=100, all other hist=0, sel_idx=15, run 2 frames -> at col 200, rows 380..479: blue=11; at row 379: black or grid only.
REQ-027 snap rows: hist_0=255, sel_idx=0 -> bar 0 is red, not green (select wins); with sel_idx=12, bar 0 is green.
REQ-028 Change hist_5 from 10 to 200 while row=100 -> the current frame still shows height 10; the next frame shows 200.
REQ-029 Latency: single visible pixel change at col 70 -> colour change appears exactly 2 cycles later; h_sync_in falling edge -> h_sync_out falls 2 cycles later.
REQ-030 Gap/edge: col 64..67 and 124..127 with hist_1=255 -> no bar colour; col 639, row 479 -> grid grey (01,01,01).
REQ-031 Assert rst for 1 cycle mid-frame -> outputs black with syncs high for 2 cycles, and no bars are drawn until the row-480 snapshot.
